isp_exposure_stats: RTL

- Downstream consumer of the gain controller's corrected 8-bit pixel stream.
- Accumulates per-frame luminance statistics and computes the rounded frame mean.
- Closes an auto-exposure loop: steps an 8-bit exposure value toward a target brightness, with hysteresis.
- Exposure output feeds the sensor-control side; mean and saturation count are exported for debug and readout.

---
 rtl/isp_exposure_stats.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/isp_exposure_stats.sv
// Per-frame luminance statistics and auto-exposure stepping on a corrected 8-bit pixel stream.
// Define ISP_EXPOSURE_SAT_EN to count saturated pixels and double the decrease step on bright frames.
`timescale 1ns / 1ps

module isp_exposure_stats #(
  parameter int unsigned IMG_W    = 32,
  parameter int unsigned IMG_H    = 32,
  parameter int unsigned TARGET   = 128,
  parameter int unsigned HYST     = 8,
  parameter int unsigned STEP     = 4,
  parameter int unsigned EXP_INIT = 64,
  parameter int unsigned EXP_MIN  = 1,
  parameter int unsigned EXP_MAX  = 255
`ifdef ISP_EXPOSURE_SAT_EN
  ,
  parameter int unsigned SAT_THR  = 250
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  input  logic                          in_sof,
  output logic [7:0]                    frame_mean,
  output logic                          mean_valid,
  output logic [7:0]                    exposure,
  output logic                          exp_update,
  output logic                          frame_err,
  output logic [$clog2(IMG_W*IMG_H):0]  sat_count
);

  localparam int unsigned N    = IMG_W * IMG_H;
  localparam int unsigned LogN = $clog2(N);
  localparam int unsigned AccW = 8 + LogN;
  localparam int unsigned SatW = LogN + 1;

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e          state_q, state_d;
  logic [AccW-1:0] sum_q, sum_d, sum_snap_q, sum_snap_d;
  logic [LogN-1:0] cnt_q, cnt_d;
  logic            snap_valid_q, snap_valid_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      frame_mean_q;
  logic            mean_valid_q;
  logic [7:0]      exposure_q, exposure_d;
  logic            exp_update_q;
  logic [9:0]      step_dn;

`ifdef ISP_EXPOSURE_SAT_EN
  logic [SatW-1:0] sat_cnt_q, sat_cnt_d, sat_snap_q, sat_snap_d, sat_count_q;
  logic [SatW-1:0] sat_inc;

  assign sat_inc = SatW'(32'(in_data) >= SAT_THR);
`endif

  // Accumulate FSM: a frame completes on its Nth pixel; an in_sof mid-frame restarts.
  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    sum_snap_d   = sum_snap_q;
    snap_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef ISP_EXPOSURE_SAT_EN
    sat_cnt_d    = sat_cnt_q;
    sat_snap_d   = sat_snap_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid && in_sof) begin
          sum_d   = AccW'(in_data);
          cnt_d   = LogN'(1);
          state_d = StAccum;
`ifdef ISP_EXPOSURE_SAT_EN
          sat_cnt_d = sat_inc;
`endif
        end
      end
      StAccum: begin
        if (in_valid) begin
          if (in_sof) begin
            frame_err_d = 1'b1;
            sum_d       = AccW'(in_data);
            cnt_d       = LogN'(1);
`ifdef ISP_EXPOSURE_SAT_EN
            sat_cnt_d   = sat_inc;
`endif
          end else if (cnt_q == LogN'(N - 1)) begin
            sum_snap_d   = sum_q + AccW'(in_data);
            snap_valid_d = 1'b1;
            sum_d        = '0;
            cnt_d        = '0;
            state_d      = StIdle;
`ifdef ISP_EXPOSURE_SAT_EN
            sat_snap_d   = sat_cnt_q + sat_inc;
            sat_cnt_d    = '0;
`endif
          end else begin
            sum_d = sum_q + AccW'(in_data);
            cnt_d = cnt_q + 1'b1;
`ifdef ISP_EXPOSURE_SAT_EN
            sat_cnt_d = sat_cnt_q + sat_inc;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Rounded mean; the shift leaves at most 9 bits, the top one only on overflow.
  logic [AccW:0] mean_round;
  logic [8:0]    mean_shift;
  logic [7:0]    mean_sat;

  assign mean_round = {1'b0, sum_snap_q} + (AccW + 1)'(N / 2);
  assign mean_shift = 9'(mean_round >> LogN);
  assign mean_sat   = mean_shift[8] ? 8'hFF : mean_shift[7:0];

  // Signed 10-bit step arithmetic so clamping never sees a wrapped value.
  logic signed [9:0] exp_up, exp_dn;

  assign exp_up = $signed({2'b00, exposure_q}) + $signed(10'(STEP));
  assign exp_dn = $signed({2'b00, exposure_q}) - $signed(step_dn);

  always_comb begin
    exposure_d = exposure_q;
    if (int'(frame_mean_q) < int'(TARGET) - int'(HYST)) begin
      exposure_d = (exp_up > $signed(10'(EXP_MAX))) ? 8'(EXP_MAX) : exp_up[7:0];
    end else if (int'(frame_mean_q) > int'(TARGET) + int'(HYST)) begin
      exposure_d = (exp_dn < $signed(10'(EXP_MIN))) ? 8'(EXP_MIN) : exp_dn[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sum_q        <= '0;
      cnt_q        <= '0;
      sum_snap_q   <= '0;
      snap_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_mean_q <= '0;
      mean_valid_q <= 1'b0;
      exposure_q   <= 8'(EXP_INIT);
      exp_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      sum_snap_q   <= sum_snap_d;
      snap_valid_q <= snap_valid_d;
      frame_err_q  <= frame_err_d;
      mean_valid_q <= snap_valid_q;
      exp_update_q <= mean_valid_q;
      if (snap_valid_q) frame_mean_q <= mean_sat;
      if (mean_valid_q) exposure_q <= exposure_d;
    end
  end

`ifdef ISP_EXPOSURE_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q   <= '0;
      sat_snap_q  <= '0;
      sat_count_q <= '0;
    end else begin
      sat_cnt_q  <= sat_cnt_d;
      sat_snap_q <= sat_snap_d;
      if (snap_valid_q) sat_count_q <= sat_snap_q;
    end
  end

  assign step_dn   = (sat_count_q > SatW'(N / 16)) ? 10'(2 * STEP) : 10'(STEP);
  assign sat_count = sat_count_q;
`else
  assign step_dn   = 10'(STEP);
  assign sat_count = '0;
`endif

  assign frame_mean = frame_mean_q;
  assign mean_valid = mean_valid_q;
  assign exposure   = exposure_q;
  assign exp_update = exp_update_q;
  assign frame_err  = frame_err_q;

endmodule
